// File: rtl/boot_seq_ctrl.sv
// Boot sequencer: waits for the ROM load to settle, lets the user review
// the loaded words, then releases the CPU and watches its fetches.
module boot_seq_ctrl #(
   parameter int QUIET_CYCLES = 1024,
   parameter int ADDR_W       = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_load_done,
   input  logic [ADDR_W-1:0] i_max_addr,
   input  logic              i_start,
   input  logic              i_step,
   input  logic [ADDR_W-1:0] i_cpu_addr,
   input  logic              i_cpu_halt,
   output logic [ADDR_W-1:0] o_rom_addr,
   output logic              o_cpu_rst,
   output logic [1:0]        o_state,
   output logic              o_error,
   output logic [15:0]       o_run_cycles
);

   typedef enum logic [1:0] {
      LOAD   = 2'd0,
      REVIEW = 2'd1,
      RUN    = 2'd2,
      HALT   = 2'd3
   } state_t;

   localparam logic [15:0] QUIET_LAST = 16'(QUIET_CYCLES - 1);

   state_t            state_q;
   logic [15:0]       quiet_q;
   logic [ADDR_W-1:0] ptr_q;
   logic [ADDR_W-1:0] max_lat_q;
   logic              cpu_rst_q;
   logic              error_q;
   logic [15:0]       run_q;

   logic quiet_ok;
   logic reload;

   // load_done is already high before the first byte, so require data too
   assign quiet_ok = i_load_done && (i_max_addr != '0);
   assign reload   = !i_load_done || (i_max_addr != max_lat_q);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= LOAD;
         quiet_q   <= '0;
         ptr_q     <= '0;
         max_lat_q <= '0;
         cpu_rst_q <= 1'b1;
         error_q   <= 1'b0;
         run_q     <= '0;
      end else begin
         unique case (state_q)
            LOAD: begin
               if (!quiet_ok) begin
                  quiet_q <= '0;
               end else if (quiet_q == QUIET_LAST) begin
                  state_q   <= REVIEW;
                  quiet_q   <= '0;
                  ptr_q     <= '0;
                  max_lat_q <= i_max_addr;
               end else begin
                  quiet_q <= quiet_q + 16'd1;
               end
            end
            REVIEW: begin
               if (reload) begin
                  state_q <= LOAD;
                  quiet_q <= '0;
               end else if (i_start) begin
                  state_q   <= RUN;
                  run_q     <= '0;
                  cpu_rst_q <= 1'b0;
               end else if (i_step) begin
                  if (ptr_q == i_max_addr)
                     ptr_q <= '0;
                  else
                     ptr_q <= ptr_q + ADDR_W'(1);
               end
            end
            RUN: begin
               if (run_q != 16'hFFFF)
                  run_q <= run_q + 16'd1;
               if (i_cpu_addr > i_max_addr) begin
                  state_q   <= HALT;
                  error_q   <= 1'b1;
                  cpu_rst_q <= 1'b1;
               end else if (i_cpu_halt) begin
                  state_q   <= HALT;
                  cpu_rst_q <= 1'b1;
               end
            end
            HALT: begin
               state_q <= HALT;
            end
            default: begin
               state_q <= LOAD;
            end
         endcase
      end
   end

   // RUN passes the fetch address straight through to keep BRAM latency at 1
   always_comb begin
      o_rom_addr = '0;
      unique case (state_q)
         RUN:     o_rom_addr = i_cpu_addr;
         REVIEW:  o_rom_addr = ptr_q;
         default: o_rom_addr = '0;
      endcase
   end

   assign o_cpu_rst    = cpu_rst_q;
   assign o_state      = state_q;
   assign o_error      = error_q;
   assign o_run_cycles = run_q;

endmodule

// File: tb/tb_boot_seq_ctrl.sv
// Directed vector bench for boot_seq_ctrl with QUIET_CYCLES=4.
module tb_boot_seq_ctrl;

   logic       clk;
   logic       rst;
   logic       load_done;
   logic [7:0] max_addr;
   logic       start;
   logic       step;
   logic [7:0] cpu_addr;
   logic       cpu_halt;
   logic [7:0] rom_addr;
   logic       cpu_rst;
   logic [1:0] state;
   logic       error;
   logic [15:0] run_cycles;

   int total;
   int bad;

   boot_seq_ctrl #(.QUIET_CYCLES(4), .ADDR_W(8)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_load_done  (load_done),
      .i_max_addr   (max_addr),
      .i_start      (start),
      .i_step       (step),
      .i_cpu_addr   (cpu_addr),
      .i_cpu_halt   (cpu_halt),
      .o_rom_addr   (rom_addr),
      .o_cpu_rst    (cpu_rst),
      .o_state      (state),
      .o_error      (error),
      .o_run_cycles (run_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          rep;
      logic        ld;
      logic [7:0]  mx;
      logic        st;
      logic        sp;
      logic [7:0]  ca;
      logic        hl;
      logic [1:0]  e_state;
      logic [7:0]  e_rom;
      logic        e_rst;
      logic        e_err;
      logic [15:0] e_run;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(int rep, logic ld, logic [7:0] mx,
                               logic st, logic sp, logic [7:0] ca,
                               logic hl, logic [1:0] es, logic [7:0] er,
                               logic erst, logic eerr, logic [15:0] erun);
      vec_t v;
      v.rep = rep; v.ld = ld; v.mx = mx; v.st = st; v.sp = sp;
      v.ca = ca; v.hl = hl; v.e_state = es; v.e_rom = er;
      v.e_rst = erst; v.e_err = eerr; v.e_run = erun;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic chk_all(string tag, logic [1:0] es, logic [7:0] er,
                          logic erst, logic eerr, logic [15:0] erun);
      chk({tag, ".state"}, 32'(state), 32'(es));
      chk({tag, ".rom"}, 32'(rom_addr), 32'(er));
      chk({tag, ".cpu_rst"}, 32'(cpu_rst), 32'(erst));
      chk({tag, ".error"}, 32'(error), 32'(eerr));
      chk({tag, ".run"}, 32'(run_cycles), 32'(erun));
   endtask

   task automatic drive(logic ld, logic [7:0] mx, logic st, logic sp,
                        logic [7:0] ca, logic hl);
      load_done = ld; max_addr = mx; start = st;
      step = sp; cpu_addr = ca; cpu_halt = hl;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      drive(1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic edge_n(int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         @(negedge clk);
      end
   endtask

   // reset, load max, wait out the quiet window, then start
   task automatic go_run(logic [7:0] mx);
      do_reset();
      drive(1'b1, mx, 1'b0, 1'b0, 8'd0, 1'b0);
      edge_n(4);
      chk("go_run.review", 32'(state), 32'd1);
      drive(1'b1, mx, 1'b1, 1'b0, 8'd0, 1'b0);
      edge_n(1);
      drive(1'b1, mx, 1'b0, 1'b0, 8'd0, 1'b0);
      chk("go_run.run", 32'(state), 32'd2);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      drive(1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0);
      #1;
      chk_all("reset", 2'd0, 8'd0, 1'b1, 1'b0, 16'd0);

      vecs.push_back(mk(10, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mk(3,  1, 5, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mk(1,  0, 5, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mk(3,  1, 5, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mk(1,  1, 5, 0, 0, 0, 0, 1, 0, 1, 0, 0));
      vecs.push_back(mk(1,  1, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mk(4,  1, 2, 0, 0, 0, 0, 1, 0, 1, 0, 0));
      vecs.push_back(mk(1,  1, 2, 0, 1, 0, 0, 1, 1, 1, 0, 0));
      vecs.push_back(mk(1,  1, 2, 0, 1, 0, 0, 1, 2, 1, 0, 0));
      vecs.push_back(mk(1,  1, 2, 0, 1, 0, 0, 1, 0, 1, 0, 0));
      vecs.push_back(mk(1,  1, 2, 0, 1, 0, 0, 1, 1, 1, 0, 0));
      vecs.push_back(mk(1,  1, 3, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mk(4,  1, 3, 0, 0, 0, 0, 1, 0, 1, 0, 0));
      vecs.push_back(mk(1,  1, 3, 0, 1, 0, 0, 1, 1, 1, 0, 0));
      vecs.push_back(mk(1,  1, 3, 1, 1, 3, 0, 2, 3, 0, 0, 0));
      vecs.push_back(mk(9,  1, 3, 0, 0, 2, 0, 2, 2, 0, 0, 9));
      vecs.push_back(mk(1,  1, 3, 0, 0, 3, 1, 3, 0, 1, 0, 10));
      vecs.push_back(mk(3,  0, 1, 1, 1, 9, 1, 3, 0, 1, 0, 10));

      @(negedge clk);
      rst = 1'b0;
      foreach (vecs[i]) begin
         drive(vecs[i].ld, vecs[i].mx, vecs[i].st, vecs[i].sp,
               vecs[i].ca, vecs[i].hl);
         for (int r = 0; r < vecs[i].rep; r++) begin
            @(posedge clk);
            #1;
            if (r == vecs[i].rep - 1)
               chk_all($sformatf("vec%0d", i), vecs[i].e_state,
                       vecs[i].e_rom, vecs[i].e_rst, vecs[i].e_err,
                       vecs[i].e_run);
            @(negedge clk);
         end
      end

      // step before REVIEW pointer advance: ptr held while start wins
      go_run(8'd5);
      cpu_addr = 8'd4;
      #1;
      chk("run.passthru", 32'(rom_addr), 32'd4);
      chk("run.cpu_rst", 32'(cpu_rst), 32'd0);

      // out-of-range fetch with halt records the error
      drive(1'b1, 8'd5, 1'b0, 1'b0, 8'd6, 1'b1);
      @(posedge clk);
      #1;
      chk_all("err_prec", 2'd3, 8'd0, 1'b1, 1'b1, 16'd1);
      @(negedge clk);
      drive(1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0);
      edge_n(3);
      chk("err_sticky", 32'(error), 32'd1);

      // boundary address with halt leaves error clear
      go_run(8'd5);
      drive(1'b1, 8'd5, 1'b0, 1'b0, 8'd5, 1'b1);
      @(posedge clk);
      #1;
      chk_all("halt_eq", 2'd3, 8'd0, 1'b1, 1'b0, 16'd1);

      // reset between edges while running
      go_run(8'd5);
      drive(1'b1, 8'd5, 1'b0, 1'b0, 8'd7, 1'b0);
      #2;
      chk("pre_rst.err", 32'(error), 32'd0);
      drive(1'b1, 8'd5, 1'b0, 1'b0, 8'd9, 1'b0);
      go_run(8'd5);
      drive(1'b1, 8'd5, 1'b0, 1'b0, 8'd7, 1'b1);
      @(posedge clk);
      #1;
      chk("err_before_rst", 32'(error), 32'd1);
      go_run(8'd5);
      drive(1'b1, 8'd5, 1'b0, 1'b0, 8'd2, 1'b0);
      edge_n(2);
      #2;
      rst = 1'b1;
      #1;
      chk_all("mid_rst", 2'd0, 8'd0, 1'b1, 1'b0, 16'd0);
      @(negedge clk);
      rst = 1'b0;
      edge_n(3);
      chk("resume.load", 32'(state), 32'd0);
      edge_n(1);
      chk("resume.review", 32'(state), 32'd1);

      // long run saturates the cycle counter
      go_run(8'd5);
      drive(1'b1, 8'd5, 1'b0, 1'b0, 8'd0, 1'b0);
      repeat (65540) @(posedge clk);
      #1;
      chk("sat.run", 32'(run_cycles), 32'hFFFF);
      chk("sat.state", 32'(state), 32'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/boot_seq_ctrl.md
# boot_seq_ctrl

Boot sequencer for the UART-loaded instruction ROM. It watches the ROM's load-done flag and highest-written address, and decides when loading has finished. It lets the user step through the loaded words for review, then releases the CPU and gives it the ROM read port. It also stops the CPU on a halt request or an out-of-range fetch, and counts run cycles for the display.

## Interface

Parameters:
- QUIET_CYCLES, 1024: consecutive cycles the load-done flag must stay high before loading counts as finished; legal range 1..65535.
- ADDR_W, 8: ROM address width.

Ports:
- i_clk  input  1  CPU-domain clock (the divided clock that also clocks the ROM BRAM).
- i_rst  input  1  asynchronous, active-high reset.
- i_load_done  input  1  ROM transmit-done level (UART idle and FIFO empty).
- i_max_addr  input  ADDR_W  highest ROM address written so far; 0 means nothing loaded yet.
- i_start  input  1  single-cycle pulse that releases the CPU.
- i_step  input  1  single-cycle pulse that advances the review pointer.
- i_cpu_addr  input  ADDR_W  CPU fetch address.
- i_cpu_halt  input  1  CPU halt request (level).
- o_rom_addr  output  ADDR_W  ROM read address.
- o_cpu_rst  output  1  holds the CPU in reset while high.
- o_state  output  2  LOAD=0, REVIEW=1, RUN=2, HALT=3.
- o_error  output  1  sticky flag for an out-of-range fetch.
- o_run_cycles  output  16  saturating count of cycles spent in RUN.

## Operation

State machine; all state registers update on the rising edge of i_clk.

- **LOAD** (reset state):
  - The quiet counter increments while i_load_done=1 and i_max_addr!=0, and clears to 0 otherwise.
  - When the counter reaches QUIET_CYCLES-1 with the condition still true, go to REVIEW and load the review pointer with 0.
  - i_start and i_step are ignored.
  - The quiet condition excludes i_max_addr==0 because i_load_done is already high before any byte arrives.
- **REVIEW**:
  - i_step advances the pointer by one. When the pointer equals i_max_addr it wraps to 0 instead.
  - i_start goes to RUN and clears o_run_cycles.
  - If i_load_done falls, or i_max_addr differs from the value latched on REVIEW entry, a reload is in progress: go back to LOAD with the quiet counter cleared. This reload check has priority over i_start.
  - If i_start and i_step arrive together, i_start wins and the pointer is unchanged.
- **RUN**:
  - o_run_cycles increments each cycle and saturates at 16'hFFFF.
  - If i_cpu_addr > i_max_addr (unsigned compare), set o_error and go to HALT.
  - Otherwise, if i_cpu_halt=1, go to HALT with o_error unchanged. When both are true together, the error is recorded.
  - i_load_done and i_max_addr changes are ignored in RUN.
- **HALT**:
  - Terminal state; only i_rst leaves it.
  - o_run_cycles is frozen.
  - All other inputs are ignored.

Outputs:
- **o_rom_addr** is a combinational mux of the registered state:
  - RUN: i_cpu_addr, a zero-latency passthrough so the CPU sees the normal one-cycle BRAM read latency.
  - REVIEW: the review pointer.
  - LOAD and HALT: 0.
- **o_cpu_rst** is registered: 0 only while the state register is RUN, 1 otherwise.
- **o_error** is registered and sticky until i_rst.

## Timing

Reset values (asynchronous assertion, effective immediately):
- o_state=0 (LOAD); quiet counter 0; review pointer 0; o_rom_addr=0.
- o_cpu_rst=1; o_error=0; o_run_cycles=0.
- Reset takes effect mid-operation in any state, including during RUN (CPU goes back into reset at once).

Cycle-level behaviour:
- **LOAD→REVIEW**: with the quiet condition first true at edge k, o_state=1 after edge k+QUIET_CYCLES-1. A condition drop at any edge before that restarts the count.
- **REVIEW→RUN**: with i_start sampled at edge k, o_state=2 and o_cpu_rst=0 after edge k. o_run_cycles becomes 1 after edge k+1.
- **RUN→HALT**: the offending address or halt is sampled at edge k; o_state=3 and o_cpu_rst=1 after edge k. o_rom_addr becomes 0 in the same cycle as the state change.
- **Step latency**: the pointer updates one edge after i_step, and the ROM data for the new address appears one further edge later.

## Test plan

- **Quiet count and reload**: QUIET_CYCLES=4; hold i_max_addr=0, i_load_done=1 for 10 cycles → stays LOAD. Set i_max_addr=5 → REVIEW exactly 4 edges later. Drop i_load_done for 1 cycle inside the window → the count restarts.
- **Review wrap**: REVIEW with i_max_addr=2; pulse i_step 4 times → o_rom_addr sequence 0,1,2,0,1. Change i_max_addr to 3 → back to LOAD with o_rom_addr=0.
- **Start**: in REVIEW, pulse i_start together with i_step → RUN, pointer unchanged, o_cpu_rst=0 next cycle. Drive i_cpu_addr=3 → o_rom_addr=3 in the same cycle.
- **Error precedence**: in RUN with i_max_addr=5, drive i_cpu_addr=6 and i_cpu_halt=1 together → HALT with o_error=1. In a separate run, i_cpu_addr=5 with i_cpu_halt=1 → HALT with o_error=0.
- **Run counter**: RUN for 10 cycles then halt → o_run_cycles=10 and stays frozen in HALT. With a forced long run, o_run_cycles saturates at 16'hFFFF.
- **Reset mid-run**: assert i_rst between clock edges while in RUN → o_cpu_rst=1, o_state=0 and o_error=0 immediately. LOAD resumes after deassertion.
